// File: rtl/clk_en_gen_multi.sv
// -----------------------------------------------------------------------------
// clk_en_gen_multi
//
// Multi-channel fractional clock-enable generator. Each channel keeps a phase
// accumulator. Whenever the channel advances, it adds its increment to the
// accumulator. The carry out of that addition becomes a single-cycle enable
// pulse, so the average pulse rate is clk * inc / 2^ACC_WIDTH.
//
// A channel (other than channel 0) can be cascaded. A cascaded channel advances
// only on cycles where the previous channel's registered pulse is high. This
// lets slow timer ticks be derived from a faster sample-rate enable.
//
// Parameters
//   NUM_CH        number of channels (>= 1)
//   ACC_WIDTH     accumulator / increment width (>= 4)
//   RESET_INC     packed reset increments, channel i at [i*ACC_WIDTH +: ACC_WIDTH]
//   RESET_EN      reset enable mask
//   RESET_CASCADE reset cascade mask (bit 0 ignored)
//
// Ports
//   clk        in   master clock
//   reset      in   synchronous active-high reset
//   sync       in   clears every accumulator and pending pulse on the next edge
//   wr_en      in   configuration write strobe
//   wr_ch      in   channel addressed by the write (out-of-range writes ignored)
//   wr_inc     in   new increment
//   wr_enable  in   new channel enable
//   wr_cascade in   new cascade select (forced 0 for channel 0)
//   clk_en     out  registered per-channel enable pulses
//   ch_enabled out  registered enable mask (mirrors the enable register)
//
// All outputs come straight from flops. No input has a combinational path
// to an output.
// -----------------------------------------------------------------------------
module clk_en_gen_multi #(
  parameter int                          NUM_CH        = 3,
  parameter int                          ACC_WIDTH     = 32,
  parameter logic [NUM_CH*ACC_WIDTH-1:0] RESET_INC     = '0,
  parameter logic [NUM_CH-1:0]           RESET_EN      = '0,
  parameter logic [NUM_CH-1:0]           RESET_CASCADE = '0,
  localparam int                         CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sync,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [ACC_WIDTH-1:0] wr_inc,
  input  logic                 wr_enable,
  input  logic                 wr_cascade,
  output logic [NUM_CH-1:0]    clk_en,
  output logic [NUM_CH-1:0]    ch_enabled
);

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc    [NUM_CH];
  logic [ACC_WIDTH-1:0] inc    [NUM_CH];
  logic [NUM_CH-1:0]    en;
  logic [NUM_CH-1:0]    cas;

  // Next-state values
  logic [ACC_WIDTH-1:0] acc_nx [NUM_CH];
  logic [ACC_WIDTH-1:0] inc_nx [NUM_CH];
  logic [NUM_CH-1:0]    en_nx;
  logic [NUM_CH-1:0]    cas_nx;
  logic [NUM_CH-1:0]    pulse_nx;

  // Advance qualification
  logic [NUM_CH-1:0]    src_ok;
  logic [NUM_CH-1:0]    adv;
  logic [NUM_CH-1:0]    wr_hit;

  // ---------------------------------------------------------------------------
  // Cascade source selection.
  // cas[0] is held at 0 by reset and by every write, so channel 0 always
  // free-runs. A cascaded channel g advances only while the registered pulse
  // of channel g-1 is high. This adds exactly one clock of skew per cascade
  // level.
  // ---------------------------------------------------------------------------
  assign src_ok[0] = ~cas[0];

  for (genvar g = 1; g < NUM_CH; g++) begin : g_cascade
    assign src_ok[g] = ~cas[g] | clk_en[g-1];
  end

  assign adv = en & src_ok;

  // ---------------------------------------------------------------------------
  // Write decode. The channel index is zero-extended before comparison, so
  // an index >= NUM_CH matches no channel and the write is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en && (32'(wr_ch) == 32'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // Priority for the accumulator and pulse:
  //   sync or (enable going 1->0)  -> clear
  //   advance                      -> acc + inc (old inc), pulse = carry
  //   otherwise                    -> hold, no pulse
  // The configuration fields update independently of the accumulator.
  // A retune therefore keeps the accumulated phase and takes effect on the
  // following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ACC_WIDTH:0] sum;
    logic               disable_now;

    sum         = '0;
    disable_now = 1'b0;
    en_nx       = en;
    cas_nx      = cas;
    pulse_nx    = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      inc_nx[i] = inc[i];
      acc_nx[i] = acc[i];

      sum         = {1'b0, acc[i]} + {1'b0, inc[i]};
      disable_now = wr_hit[i] && en[i] && !wr_enable;

      if (wr_hit[i]) begin
        inc_nx[i] = wr_inc;
        en_nx[i]  = wr_enable;
        cas_nx[i] = (i == 0) ? 1'b0 : wr_cascade;
      end

      if (sync || disable_now) begin
        acc_nx[i]   = '0;
        pulse_nx[i] = 1'b0;
      end else if (adv[i]) begin
        acc_nx[i]   = sum[ACC_WIDTH-1:0];
        pulse_nx[i] = sum[ACC_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= RESET_INC[i*ACC_WIDTH +: ACC_WIDTH];
      end
      en     <= RESET_EN;
      cas    <= RESET_CASCADE & ~NUM_CH'(1);
      clk_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= acc_nx[i];
        inc[i] <= inc_nx[i];
      end
      en     <= en_nx;
      cas    <= cas_nx;
      clk_en <= pulse_nx;
    end
  end

  assign ch_enabled = en;

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen_multi
//
// Directed bench for clk_en_gen_multi with NUM_CH=3 and ACC_WIDTH=8.
// At reset, channel 0 runs with inc=64 and the other channels are disabled.
// Inputs are driven 1 ns after the rising edge. Outputs are checked at the
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_clk_en_gen_multi;

  localparam int NUM_CH    = 3;
  localparam int ACC_WIDTH = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sync;
  logic                 wr_en;
  logic [1:0]           wr_ch;
  logic [ACC_WIDTH-1:0] wr_inc;
  logic                 wr_enable;
  logic                 wr_cascade;
  logic [NUM_CH-1:0]    clk_en;
  logic [NUM_CH-1:0]    ch_enabled;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  clk_en_gen_multi #(
    .NUM_CH        (NUM_CH),
    .ACC_WIDTH     (ACC_WIDTH),
    .RESET_INC     (24'h00_00_40),
    .RESET_EN      (3'b001),
    .RESET_CASCADE (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_inc     (wr_inc),
    .wr_enable  (wr_enable),
    .wr_cascade (wr_cascade),
    .clk_en     (clk_en),
    .ch_enabled (ch_enabled)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One configuration write (optionally combined with sync), consuming one edge.
  task automatic wr_cycle(input int ch, input logic [ACC_WIDTH-1:0] inc,
                          input logic en, input logic cas, input logic syn);
    wr_en      = 1'b1;
    wr_ch      = 2'(ch);
    wr_inc     = inc;
    wr_enable  = en;
    wr_cascade = cas;
    sync       = syn;
    step();
    wr_en      = 1'b0;
    sync       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test 1: reset values and the inc=64 pattern from the reset configuration
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [NUM_CH-1:0] exp;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (clk_en !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_clk_en: got %b expected %b", clk_en, 3'b000);
    end
    n_checks++;
    if (ch_enabled !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ch_enabled: got %b expected %b", ch_enabled, 3'b001);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k % 4 == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if (clk_en !== exp) begin
        n_fail++;
        $display("FAIL inc64_cycle%0d: got %b expected %b", k, clk_en, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test 2: inc=96 gives pulses on advances 3, 6 and 8 of every 8 cycles
  // ---------------------------------------------------------------------------
  task automatic test_fractional();
    logic [NUM_CH-1:0] exp;
    int                pulses;
    wr_cycle(0, 8'd96, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (clk_en !== 3'b000) begin
      n_fail++;
      $display("FAIL frac_after_sync: got %b expected %b", clk_en, 3'b000);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = ((k % 8 == 3) || (k % 8 == 6) || (k % 8 == 0)) ? 3'b001 : 3'b000;
      n_checks++;
      if (clk_en !== exp) begin
        n_fail++;
        $display("FAIL inc96_cycle%0d: got %b expected %b", k, clk_en, exp);
      end
    end
    pulses = 0;
    for (int k = 0; k < 800; k++) begin
      step();
      if (clk_en[0] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 300) begin
      n_fail++;
      $display("FAIL inc96_800cyc_count: got %0d expected %0d", pulses, 300);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test 3: cascade ch0 inc=128 -> ch1 inc=64
  // ---------------------------------------------------------------------------
  task automatic test_cascade();
    logic [NUM_CH-1:0] exp;
    int                c0;
    int                c1;
    wr_cycle(1, 8'd64, 1'b1, 1'b1, 1'b1);
    wr_cycle(0, 8'd128, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (clk_en !== 3'b000 || ch_enabled !== 3'b011) begin
      n_fail++;
      $display("FAIL cascade_setup: got clk_en=%b ch_enabled=%b expected 000/011",
               clk_en, ch_enabled);
    end
    c0 = 0;
    c1 = 0;
    for (int k = 1; k <= 33; k++) begin
      step();
      exp    = 3'b000;
      exp[0] = (k % 2 == 0);
      exp[1] = (k % 8 == 1) && (k > 1);
      if (clk_en[0] === 1'b1) c0++;
      if (clk_en[1] === 1'b1) c1++;
      n_checks++;
      if (clk_en !== exp) begin
        n_fail++;
        $display("FAIL cascade_cycle%0d: got %b expected %b", k, clk_en, exp);
      end
    end
    n_checks++;
    if (c0 != 16 || c1 != 4) begin
      n_fail++;
      $display("FAIL cascade_ratio: got ch0=%0d ch1=%0d expected ch0=16 ch1=4", c0, c1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test 4: retune ch0 from 64 to 32 while acc=192
  // ---------------------------------------------------------------------------
  task automatic test_retune();
    logic exp;
    wr_cycle(0, 8'd64, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (clk_en[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL retune_pre%0d: got %b expected 0", k, clk_en[0]);
      end
    end
    // acc0 = 192 now; the write-cycle advance still uses inc=64 and overflows
    wr_cycle(0, 8'd32, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (clk_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL retune_write_cycle: got %b expected 1", clk_en[0]);
    end
    for (int k = 5; k <= 12; k++) begin
      step();
      exp = (k == 12);
      n_checks++;
      if (clk_en[0] !== exp) begin
        n_fail++;
        $display("FAIL retune_cycle%0d: got %b expected %b", k, clk_en[0], exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test 5: sync override, disable clears acc, out-of-range write ignored
  // ---------------------------------------------------------------------------
  task automatic test_sync_disable();
    logic [NUM_CH-1:0] exp;
    wr_cycle(0, 8'd96, 1'b1, 1'b0, 1'b0);
    wr_cycle(1, 8'd64, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (clk_en !== 3'b000 || ch_enabled !== 3'b011) begin
      n_fail++;
      $display("FAIL sync_setup: got clk_en=%b ch_enabled=%b expected 000/011",
               clk_en, ch_enabled);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      n_checks++;
      if (clk_en !== 3'b000) begin
        n_fail++;
        $display("FAIL sync_pre%0d: got %b expected 000", k, clk_en);
      end
    end
    // acc0=192, acc1=128: without sync ch0 would overflow on this edge
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_checks++;
    if (clk_en !== 3'b000) begin
      n_fail++;
      $display("FAIL sync_override: got %b expected 000", clk_en);
    end
    for (int k = 4; k <= 7; k++) begin
      step();
      exp = {1'b0, (k == 7), (k == 6)};
      n_checks++;
      if (clk_en !== exp) begin
        n_fail++;
        $display("FAIL sync_post%0d: got %b expected %b", k, clk_en, exp);
      end
    end
    step();  // acc1 = 64
    wr_cycle(1, 8'd64, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ch_enabled !== 3'b001 || clk_en[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_ch1: got ch_enabled=%b clk_en1=%b expected 001/0",
               ch_enabled, clk_en[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (clk_en[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_idle%0d: got %b expected 0", k, clk_en[1]);
      end
    end
    // Re-enable: a cleared accumulator takes 4 advances of 64 to overflow
    wr_cycle(1, 8'd64, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ch_enabled !== 3'b011) begin
      n_fail++;
      $display("FAIL reenable_ch1: got %b expected 011", ch_enabled);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (clk_en[1] !== (k == 4)) begin
        n_fail++;
        $display("FAIL reenable_cycle%0d: got %b expected %b", k, clk_en[1], (k == 4));
      end
    end
    wr_cycle(3, 8'd255, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ch_enabled !== 3'b011 || clk_en[2:1] !== 2'b00) begin
      n_fail++;
      $display("FAIL bad_wr_ch: got ch_enabled=%b clk_en=%b expected 011/0xx",
               ch_enabled, clk_en);
    end
    for (int k = 6; k <= 8; k++) begin
      step();
      exp = {1'b0, (k == 8), 1'b0};
      n_checks++;
      if (clk_en[2:1] !== exp[2:1]) begin
        n_fail++;
        $display("FAIL bad_wr_after%0d: got %b expected %b", k, clk_en[2:1], exp[2:1]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Back-to-back pulses with inc=255 on channel 2
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    wr_cycle(2, 8'd255, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (clk_en[2] !== (k != 1)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", k, clk_en[2], (k != 1));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test 6: reset mid-stream on a cycle where a pulse is due
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [NUM_CH-1:0] exp;
    wr_cycle(0, 8'd96, 1'b1, 1'b0, 1'b1);
    step();
    step();  // acc0 = 192, ch2 pulsing every cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (clk_en !== 3'b000 || ch_enabled !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid: got clk_en=%b ch_enabled=%b expected 000/001",
               clk_en, ch_enabled);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k % 4 == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if (clk_en !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_cycle%0d: got %b expected %b", k, clk_en, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    sync       = 1'b0;
    wr_en      = 1'b0;
    wr_ch      = '0;
    wr_inc     = '0;
    wr_enable  = 1'b0;
    wr_cascade = 1'b0;
    #1;
    test_reset();
    test_fractional();
    test_cascade();
    test_retune();
    test_sync_disable();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
